// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one immediate-extension unit between two requesters;
// extended results and source IDs are queued in a small output FIFO.
module ext_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_imm,
  input  logic [1:0]  req0_eop,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_imm,
  input  logic [1:0]  req1_eop,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_src,
  input  logic        out_ready
);

  logic [AW:0]   count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic          pri_reg;
  logic [32:0]   mem_reg [DEPTH];

  logic          full, grant0, grant1, push, pop, src_sel;
  logic [15:0]   imm_sel;
  logic [1:0]    eop_sel;
  logic [31:0]   ext_val;

  function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] eop);
    logic [31:0] r;
    case (eop)
      2'b00:   r = {{16{imm[15]}}, imm};
      2'b01:   r = {16'h0000, imm};
      2'b10:   r = {imm, 16'h0000};
      default: r = {{14{imm[15]}}, imm, 2'b00};
    endcase
    return r;
  endfunction

  // A lone requester always wins; pri only breaks ties.
  assign full   = (count_reg == (AW+1)'(DEPTH));
  assign grant0 = !full && req0_valid && (!req1_valid || !pri_reg);
  assign grant1 = !full && req1_valid && (!req0_valid ||  pri_reg);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign push    = grant0 || grant1;
  assign src_sel = grant1;
  assign imm_sel = grant1 ? req1_imm : req0_imm;
  assign eop_sel = grant1 ? req1_eop : req0_eop;
  assign ext_val = extend(imm_sel, eop_sel);

  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_reg[rd_ptr_reg][31:0];
  assign out_src   = mem_reg[rd_ptr_reg][32];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      pri_reg    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        mem_reg[wr_ptr_reg] <= {src_sel, ext_val};
        wr_ptr_reg          <= wr_ptr_reg + AW'(1);
        pri_reg             <= ~src_sel;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed self-checking bench for ext_arbiter: extension ops, round-robin order,
// full/wrap behaviour, simultaneous push/pop and mid-operation reset.
module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_imm, req1_imm;
  logic [1:0]  req0_eop, req1_eop;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_src, out_ready;
  logic [31:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  ext_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_eop(req0_eop), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_eop(req1_eop), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
  endtask

  logic [15:0] eimm [4];
  logic [1:0]  eeop [4];
  logic [31:0] eexp [4];

  initial begin
    eimm[0] = 16'h8001; eeop[0] = 2'b01; eexp[0] = 32'h00008001;
    eimm[1] = 16'h1234; eeop[1] = 2'b10; eexp[1] = 32'h12340000;
    eimm[2] = 16'hFFFF; eeop[2] = 2'b11; eexp[2] = 32'hFFFFFFFC;
    eimm[3] = 16'h0003; eeop[3] = 2'b11; eexp[3] = 32'h0000000C;

    reset = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b0; req0_imm = '0; req0_eop = '0;
    req1_valid = 1'b0; req1_imm = '0; req1_eop = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", 32'(out_src), 0);

    // First request: sign-extend on req0
    req0_valid = 1'b1; req0_imm = 16'h8001; req0_eop = 2'b00; out_ready = 1'b1;
    #1;
    check("first_req0_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    check("first_out_valid", 32'(out_valid), 1);
    check("first_out_data", out_data, 32'hFFFF8001);
    check("first_out_src", 32'(out_src), 0);
    tick();
    check("first_drained", 32'(out_valid), 0);

    // EOp coverage on req1
    for (int k = 0; k < 4; k++) begin
      req1_valid = 1'b1; req1_imm = eimm[k]; req1_eop = eeop[k];
      #1;
      check($sformatf("eop%0d_req1_ready", k), 32'(req1_ready), 1);
      tick();
      req1_valid = 1'b0;
      check($sformatf("eop%0d_out_data", k), out_data, eexp[k]);
      check($sformatf("eop%0d_out_src", k), 32'(out_src), 1);
      tick();
      check($sformatf("eop%0d_drained", k), 32'(out_valid), 0);
    end

    // Round robin: last accept was req1, so req0 goes first
    req0_valid = 1'b1; req0_imm = 16'h0010; req0_eop = 2'b01;
    req1_valid = 1'b1; req1_imm = 16'h0020; req1_eop = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d_req0_ready", k), 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_req1_ready", k), 32'(req1_ready), (k % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("rr%0d_out_src", k), 32'(out_src), (k % 2 == 1) ? 1 : 0);
      check($sformatf("rr%0d_out_data", k), out_data, (k % 2 == 1) ? 32'h00000020 : 32'h00000010);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("rr_drained", 32'(out_valid), 0);

    // Fill to full with out_ready low
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_eop = 2'b01;
    for (int k = 0; k < 4; k++) begin
      req0_imm = 16'h0100 + 16'(k);
      #1;
      check($sformatf("fill%0d_req0_ready", k), 32'(req0_ready), 1);
      tick();
    end
    req0_imm = 16'h0104;
    check("full_req0_ready", 32'(req0_ready), 0);
    check("full_head", out_data, 32'h00000100);
    tick();
    check("full_hold_ready", 32'(req0_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("after_pop_head", out_data, 32'h00000101);
    check("after_pop_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    check("refull_ready", 32'(req0_ready), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap%0d_valid", k), 32'(out_valid), 1);
      check($sformatf("wrap%0d_data", k), out_data, 32'h00000101 + 32'(k));
      tick();
    end
    check("wrap_drained", 32'(out_valid), 0);

    // Simultaneous push and pop at count=2
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_eop = 2'b01; req1_imm = 16'h0200;
    tick();
    req1_imm = 16'h0201;
    tick();
    check("pp_head_before", out_data, 32'h00000200);
    req1_imm = 16'h0202; out_ready = 1'b1;
    #1;
    check("pp_req1_ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0; out_ready = 1'b0;
    check("pp_head_after", out_data, 32'h00000201);
    out_ready = 1'b1;
    tick();
    check("pp_second", out_data, 32'h00000202);
    check("pp_second_valid", 32'(out_valid), 1);
    tick();
    check("pp_drained", 32'(out_valid), 0);

    // Queue 3 entries, last from req0 so pri points at req1, then reset
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_imm = 16'h0300; tick();
    req1_imm = 16'h0301; tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_imm = 16'h0302; req0_eop = 2'b01; tick();
    check("prerst_valid", 32'(out_valid), 1);
    req1_valid = 1'b1; req1_imm = 16'h0400;
    req0_imm = 16'h0500;
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_req0_ready", 32'(req0_ready), 1);
    check("midrst_req1_ready", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("midrst_grant_src", 32'(out_src), 0);
    check("midrst_grant_data", out_data, 32'h00000500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
